// File: rtl/cache_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cache_bus_arbiter
// Description : Arbitrates the i_cache and d_cache request ports onto a single
//               AXI-bridge request interface, one outstanding transaction at
//               a time, with round-robin or fixed data-first priority.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_bus_arbiter #(
    parameter int RR_EN = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic [31:0] inst_rdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [1:0]  bus_size,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    // Owner / last-grant encoding: 0 = inst port, 1 = data port.
    localparam logic c_grant_inst = 1'b0;

    state_t      r_state;
    state_t      w_next;
    logic        r_owner;
    logic        r_last_grant;
    logic        r_wr;
    logic [1:0]  r_size;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        w_any_req;
    logic        w_grant_data;

    assign w_any_req = inst_req | data_req;

    // Data wins when it is alone, when priority is fixed, or when inst was
    // the previous owner under round-robin.
    assign w_grant_data = data_req &
                          (~inst_req | (RR_EN == 0) | (r_last_grant == c_grant_inst));

    // Next-state logic; stray bus_data_ok outside DATA has no effect.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_any_req)   w_next = ADDR;
            ADDR:    if (bus_addr_ok) w_next = DATA;
            DATA:    if (bus_data_ok) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // State, grant bookkeeping and the latched request copy.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_owner      <= c_grant_inst;
            r_last_grant <= c_grant_inst;
            r_wr         <= 1'b0;
            r_size       <= 2'd0;
            r_addr       <= 32'd0;
            r_wdata      <= 32'd0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_any_req) begin
                r_owner <= w_grant_data;
                r_wr    <= w_grant_data ? data_wr    : inst_wr;
                r_size  <= w_grant_data ? data_size  : inst_size;
                r_addr  <= w_grant_data ? data_addr  : inst_addr;
                r_wdata <= w_grant_data ? data_wdata : inst_wdata;
            end
            if (r_state == DATA && bus_data_ok) begin
                r_last_grant <= r_owner;
            end
        end
    end

    // Bus side is driven only from the latched copy, so requester changes
    // after grant cannot disturb an in-flight transaction.
    assign bus_req   = (r_state == ADDR);
    assign bus_wr    = r_wr;
    assign bus_size  = r_size;
    assign bus_addr  = r_addr;
    assign bus_wdata = r_wdata;

    // Handshakes are routed to the owner only.
    assign inst_addr_ok = (r_state == ADDR) & bus_addr_ok & ~r_owner;
    assign data_addr_ok = (r_state == ADDR) & bus_addr_ok &  r_owner;
    assign inst_data_ok = (r_state == DATA) & bus_data_ok & ~r_owner;
    assign data_data_ok = (r_state == DATA) & bus_data_ok &  r_owner;

    assign inst_rdata = bus_rdata;
    assign data_rdata = bus_rdata;

endmodule
`default_nettype wire

// File: tb/tb_cache_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_bus_arbiter
// Description : Directed self-checking bench for cache_bus_arbiter. Instance 0
//               uses fixed priority, instance 1 round-robin; both see the
//               same stimulus and stay cycle-aligned.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inst_req = 1'b0, inst_wr = 1'b0;
    logic [1:0]  inst_size = 2'd0;
    logic [31:0] inst_addr = '0, inst_wdata = '0;
    logic        data_req = 1'b0, data_wr = 1'b0;
    logic [1:0]  data_size = 2'd0;
    logic [31:0] data_addr = '0, data_wdata = '0;
    logic [31:0] bus_rdata = '0;
    logic        bus_addr_ok = 1'b0, bus_data_ok = 1'b0;

    logic [1:0]        inst_addr_ok_o, inst_data_ok_o, data_addr_ok_o, data_data_ok_o;
    logic [1:0]        bus_req_o, bus_wr_o;
    logic [1:0][1:0]   bus_size_o;
    logic [1:0][31:0]  bus_addr_o, bus_wdata_o, inst_rdata_o, data_rdata_o;

    int n_assert = 0;
    int n_fail   = 0;

    localparam int FIX = 0;
    localparam int RR  = 1;

    always #5 clk = ~clk;

    cache_bus_arbiter #(.RR_EN(0)) u_fix (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_rdata(inst_rdata_o[0]),
        .inst_addr_ok(inst_addr_ok_o[0]), .inst_data_ok(inst_data_ok_o[0]),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata_o[0]),
        .data_addr_ok(data_addr_ok_o[0]), .data_data_ok(data_data_ok_o[0]),
        .bus_req(bus_req_o[0]), .bus_wr(bus_wr_o[0]), .bus_size(bus_size_o[0]),
        .bus_addr(bus_addr_o[0]), .bus_wdata(bus_wdata_o[0]), .bus_rdata(bus_rdata),
        .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok)
    );

    cache_bus_arbiter #(.RR_EN(1)) u_rr (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_rdata(inst_rdata_o[1]),
        .inst_addr_ok(inst_addr_ok_o[1]), .inst_data_ok(inst_data_ok_o[1]),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata_o[1]),
        .data_addr_ok(data_addr_ok_o[1]), .data_data_ok(data_data_ok_o[1]),
        .bus_req(bus_req_o[1]), .bus_wr(bus_wr_o[1]), .bus_size(bus_size_o[1]),
        .bus_addr(bus_addr_o[1]), .bus_wdata(bus_wdata_o[1]), .bus_rdata(bus_rdata),
        .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // All four handshake outputs of instance d are low.
    task automatic chk_quiet(input string tag, input int d);
        chk({tag, "_inst_addr_ok"}, 32'(inst_addr_ok_o[d]), 32'd0);
        chk({tag, "_data_addr_ok"}, 32'(data_addr_ok_o[d]), 32'd0);
        chk({tag, "_inst_data_ok"}, 32'(inst_data_ok_o[d]), 32'd0);
        chk({tag, "_data_data_ok"}, 32'(data_data_ok_o[d]), 32'd0);
    endtask

    // One full transaction, entered in an IDLE cycle with requests already
    // driven. Bridge stalls aw cycles before addr_ok and dw before data_ok.
    // When scr is set the data requester withdraws and scrambles its fields
    // right after grant.
    task automatic xact(input string tag, input int d, input bit own_data,
                        input logic [31:0] ea, input logic ew, input logic [1:0] es,
                        input logic [31:0] ewd, input int aw, input int dw,
                        input bit scr, input logic [31:0] rd);
        logic own_ok, oth_ok;
        #1;
        chk({tag, "_idle_bus_req"}, 32'(bus_req_o[d]), 32'd0);
        tick();
        if (scr) begin
            data_req   = 1'b0;
            data_addr  = 32'd0;
            data_wdata = 32'd0;
            data_wr    = 1'b0;
        end
        for (int i = 0; i < aw; i++) begin
            bus_addr_ok = 1'b0;
            #1;
            chk({tag, "_wait_bus_req"}, 32'(bus_req_o[d]), 32'd1);
            chk({tag, "_wait_addr"}, bus_addr_o[d], ea);
            chk_quiet({tag, "_wait"}, d);
            tick();
        end
        bus_addr_ok = 1'b1;
        #1;
        own_ok = own_data ? data_addr_ok_o[d] : inst_addr_ok_o[d];
        oth_ok = own_data ? inst_addr_ok_o[d] : data_addr_ok_o[d];
        chk({tag, "_bus_req"}, 32'(bus_req_o[d]), 32'd1);
        chk({tag, "_bus_addr"}, bus_addr_o[d], ea);
        chk({tag, "_bus_wr"}, 32'(bus_wr_o[d]), 32'(ew));
        chk({tag, "_bus_size"}, 32'(bus_size_o[d]), 32'(es));
        chk({tag, "_bus_wdata"}, bus_wdata_o[d], ewd);
        chk({tag, "_own_addr_ok"}, 32'(own_ok), 32'd1);
        chk({tag, "_oth_addr_ok"}, 32'(oth_ok), 32'd0);
        tick();
        bus_addr_ok = 1'b0;
        for (int i = 0; i < dw; i++) begin
            #1;
            chk({tag, "_dwait_bus_req"}, 32'(bus_req_o[d]), 32'd0);
            chk_quiet({tag, "_dwait"}, d);
            tick();
        end
        bus_data_ok = 1'b1;
        bus_rdata   = rd;
        #1;
        own_ok = own_data ? data_data_ok_o[d] : inst_data_ok_o[d];
        oth_ok = own_data ? inst_data_ok_o[d] : data_data_ok_o[d];
        chk({tag, "_data_bus_req"}, 32'(bus_req_o[d]), 32'd0);
        chk({tag, "_data_bus_addr"}, bus_addr_o[d], ea);
        chk({tag, "_own_data_ok"}, 32'(own_ok), 32'd1);
        chk({tag, "_oth_data_ok"}, 32'(oth_ok), 32'd0);
        chk({tag, "_inst_rdata"}, inst_rdata_o[d], rd);
        chk({tag, "_data_rdata"}, data_rdata_o[d], rd);
        tick();
        bus_data_ok = 1'b0;
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_bus_req_rr", 32'(bus_req_o[RR]), 32'd0);
        chk("rst_bus_addr_rr", bus_addr_o[RR], 32'd0);
        chk("rst_bus_wdata_rr", bus_wdata_o[RR], 32'd0);
        chk("rst_bus_req_fix", 32'(bus_req_o[FIX]), 32'd0);
        chk_quiet("rst_rr", RR);
        chk_quiet("rst_fix", FIX);
        tick();

        // Single inst read, one stall cycle before each handshake
        inst_req  = 1'b1;
        inst_addr = 32'hBFC0_0000;
        xact("inst_rd", RR, 1'b0, 32'hBFC0_0000, 1'b0, 2'd0, 32'd0, 1, 1, 1'b0, 32'h3C1D_8000);
        inst_req = 1'b0;

        // Round-robin contention from reset: data, inst, data
        rst = 1'b1;
        tick();
        rst = 1'b0;
        inst_req  = 1'b1;
        inst_addr = 32'h8000_0000;
        data_req  = 1'b1;
        data_addr = 32'h8000_1000;
        xact("rr1", RR, 1'b1, 32'h8000_1000, 1'b0, 2'd0, 32'd0, 0, 0, 1'b0, 32'h1111_0001);
        xact("rr2", RR, 1'b0, 32'h8000_0000, 1'b0, 2'd0, 32'd0, 0, 0, 1'b0, 32'h1111_0002);
        xact("rr3", RR, 1'b1, 32'h8000_1000, 1'b0, 2'd0, 32'd0, 0, 0, 1'b0, 32'h1111_0003);

        // Fixed priority contention: three data transactions
        xact("fix1", FIX, 1'b1, 32'h8000_1000, 1'b0, 2'd0, 32'd0, 0, 0, 1'b0, 32'h2222_0001);
        xact("fix2", FIX, 1'b1, 32'h8000_1000, 1'b0, 2'd0, 32'd0, 0, 0, 1'b0, 32'h2222_0002);
        xact("fix3", FIX, 1'b1, 32'h8000_1000, 1'b0, 2'd0, 32'd0, 0, 0, 1'b0, 32'h2222_0003);
        inst_req = 1'b0;
        data_req = 1'b0;

        // Data write, requester withdraws and scrambles fields after grant
        data_req   = 1'b1;
        data_wr    = 1'b1;
        data_size  = 2'd2;
        data_addr  = 32'h8000_2004;
        data_wdata = 32'hDEAD_BEEF;
        xact("dwr", RR, 1'b1, 32'h8000_2004, 1'b1, 2'd2, 32'hDEAD_BEEF, 1, 1, 1'b1, 32'h0);
        data_size = 2'd0;

        // Reset in DATA, then a spurious bus_data_ok
        inst_req  = 1'b1;
        inst_addr = 32'h8000_0040;
        tick();
        inst_req    = 1'b0;
        bus_addr_ok = 1'b1;
        tick();
        bus_addr_ok = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("rstdata_bus_req", 32'(bus_req_o[RR]), 32'd0);
        chk_quiet("rstdata", RR);
        tick();
        tick();
        bus_data_ok = 1'b1;
        #1;
        chk_quiet("spurious", RR);
        chk_quiet("spurious_fix", FIX);
        tick();
        bus_data_ok = 1'b0;
        #1;
        chk("spurious_stays_idle", 32'(bus_req_o[RR]), 32'd0);
        inst_req  = 1'b1;
        inst_addr = 32'h8000_0000;
        data_req  = 1'b1;
        data_addr = 32'h8000_1000;
        xact("post_rst", RR, 1'b1, 32'h8000_1000, 1'b0, 2'd0, 32'd0, 0, 0, 1'b0, 32'h3333_0001);
        inst_req = 1'b0;
        data_req = 1'b0;
        tick();

        // Long address stall: ten cycles without bus_addr_ok
        inst_req  = 1'b1;
        inst_addr = 32'h8000_0100;
        xact("stall", RR, 1'b0, 32'h8000_0100, 1'b0, 2'd0, 32'd0, 10, 0, 1'b0, 32'h4444_0001);
        inst_req = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
